// File: rtl/game_sequencer_if.sv
// Signal bundle between the match sequencer and the rest of the game:
// player/video events in, match status and motion control out.
interface game_sequencer_if;
    logic       frame_tick;
    logic       serve_btn;
    logic       miss_left;
    logic       miss_right;
    logic       round_reset;
    logic       start;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       serve_dir;
    logic       winner;
    logic [2:0] state;

    modport master (
        output frame_tick, serve_btn, miss_left, miss_right,
        input  round_reset, start, score_l, score_r, serve_dir, winner, state
    );

    modport slave (
        input  frame_tick, serve_btn, miss_left, miss_right,
        output round_reset, start, score_l, score_r, serve_dir, winner, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Match sequencer for a two-player paddle game: serve countdown, rally,
// point pause, scoring and game-over, all outputs registered.
module game_sequencer #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       reset,
    game_sequencer_if.slave gs
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] POINT_LOAD = CW'(POINT_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          start_reg, start_next;
    logic          round_reset_reg, round_reset_next;
    logic          serve_dir_reg, serve_dir_next;
    logic          winner_reg, winner_next;

    // award[0]: left player scores, award[1]: right player scores
    logic          clear_scores;
    logic [1:0]    award;
    logic [1:0][3:0] score;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            count_reg       <= '0;
            start_reg       <= 1'b0;
            round_reset_reg <= 1'b0;
            serve_dir_reg   <= 1'b1;
            winner_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            start_reg       <= start_next;
            round_reset_reg <= round_reset_next;
            serve_dir_reg   <= serve_dir_next;
            winner_reg      <= winner_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        start_next       = 1'b0;
        round_reset_next = 1'b0;
        serve_dir_next   = serve_dir_reg;
        winner_next      = winner_reg;
        clear_scores     = 1'b0;
        award            = 2'b00;

        case (state_reg)
            S_IDLE, S_OVER: begin
                if (gs.serve_btn) begin
                    clear_scores     = 1'b1;
                    serve_dir_next   = 1'b1;
                    state_next       = S_SERVE;
                    round_reset_next = 1'b1;
                    count_next       = SERVE_LOAD;
                end
            end

            S_SERVE: begin
                if (gs.frame_tick) begin
                    if (count_reg == '0) begin
                        state_next = S_PLAY;
                        start_next = 1'b1;
                    end else begin
                        count_next = count_reg - 1'b1;
                    end
                end
            end

            S_PLAY: begin
                start_next = 1'b1;
                if (gs.miss_left || gs.miss_right) begin
                    state_next = S_POINT;
                    start_next = 1'b0;
                    count_next = POINT_LOAD;
                    // Simultaneous misses are a dead ball: nobody scores
                    if (gs.miss_left && !gs.miss_right) begin
                        award[1]       = 1'b1;
                        serve_dir_next = 1'b0;
                    end else if (gs.miss_right && !gs.miss_left) begin
                        award[0]       = 1'b1;
                        serve_dir_next = 1'b1;
                    end
                end
            end

            S_POINT: begin
                if (gs.frame_tick) begin
                    if (count_reg == '0) begin
                        if (score[0] == WIN || score[1] == WIN) begin
                            state_next  = S_OVER;
                            winner_next = (score[1] == WIN);
                        end else begin
                            state_next       = S_SERVE;
                            round_reset_next = 1'b1;
                            count_next       = SERVE_LOAD;
                        end
                    end else begin
                        count_next = count_reg - 1'b1;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Per-player score registers; saturate at the winning score
    for (genvar gi = 0; gi < 2; gi++) begin : g_score
        logic [3:0] score_reg;

        always_ff @(posedge clk) begin
            if (reset || clear_scores) begin
                score_reg <= '0;
            end else if (award[gi] && (score_reg < WIN)) begin
                score_reg <= score_reg + 4'd1;
            end
        end

        assign score[gi] = score_reg;
    end

    assign gs.state       = state_reg;
    assign gs.start       = start_reg;
    assign gs.round_reset = round_reset_reg;
    assign gs.serve_dir   = serve_dir_reg;
    assign gs.winner      = winner_reg;
    assign gs.score_l     = score[0];
    assign gs.score_r     = score[1];

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, hand-built reset/hold
// sequences, and random traffic checked against a rule-level match model.
module tb_game_sequencer;

    localparam int W  = 2;
    localparam int SF = 2;
    localparam int PF = 2;

    logic clk = 1'b0;
    logic reset;

    game_sequencer_if gs();

    game_sequencer #(
        .WIN_SCORE   (W),
        .SERVE_FRAMES(SF),
        .POINT_FRAMES(PF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .gs   (gs)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0..4 = idle/serve/play/point/over, ticks = ticks still needed
    int m_phase, m_ticks, m_sl, m_sr, m_dir, m_win, m_rr, m_start;

    task automatic model_step(input logic r, t, b, ml, mr);
        m_rr = 0;
        if (r) begin
            m_phase = 0; m_ticks = 0; m_sl = 0; m_sr = 0;
            m_dir = 1; m_win = 0; m_start = 0;
        end else begin
            case (m_phase)
                0, 4: if (b) begin
                    m_sl = 0; m_sr = 0; m_dir = 1;
                    m_phase = 1; m_rr = 1; m_ticks = SF;
                end
                1: if (t) begin
                    m_ticks--;
                    if (m_ticks == 0) begin m_phase = 2; m_start = 1; end
                end
                2: if (ml || mr) begin
                    if (ml && !mr) begin
                        if (m_sr < W) m_sr++;
                        m_dir = 0;
                    end else if (mr && !ml) begin
                        if (m_sl < W) m_sl++;
                        m_dir = 1;
                    end
                    m_phase = 3; m_start = 0; m_ticks = PF;
                end
                3: if (t) begin
                    m_ticks--;
                    if (m_ticks == 0) begin
                        if (m_sl == W || m_sr == W) begin
                            m_phase = 4; m_win = (m_sr == W) ? 1 : 0;
                        end else begin
                            m_phase = 1; m_rr = 1; m_ticks = SF;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, sl, sr, go, rr, dir, win);
        chk({tag, ".state"},       32'(gs.state),       st);
        chk({tag, ".score_l"},     32'(gs.score_l),     sl);
        chk({tag, ".score_r"},     32'(gs.score_r),     sr);
        chk({tag, ".start"},       32'(gs.start),       go);
        chk({tag, ".round_reset"}, 32'(gs.round_reset), rr);
        chk({tag, ".serve_dir"},   32'(gs.serve_dir),   dir);
        if (st == 4) chk({tag, ".winner"}, 32'(gs.winner), win);
    endtask

    // Drive inputs on the falling edge, advance one rising edge, sample 1 ns later
    task automatic apply(input logic r, t, b, ml, mr);
        @(negedge clk);
        reset         = r;
        gs.frame_tick = t;
        gs.serve_btn  = b;
        gs.miss_left  = ml;
        gs.miss_right = mr;
        @(posedge clk);
        model_step(r, t, b, ml, mr);
        #1;
    endtask

    typedef struct {
        logic r, t, b, ml, mr;
        int   st, sl, sr, go, rr, dir, win;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, t, b, ml, mr, input int st, sl, sr, go, rr, dir, win);
        vec_t v;
        v.r = r; v.t = t; v.b = b; v.ml = ml; v.mr = mr;
        v.st = st; v.sl = sl; v.sr = sr; v.go = go; v.rr = rr; v.dir = dir; v.win = win;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        gs.frame_tick = 1'b0;
        gs.serve_btn  = 1'b0;
        gs.miss_left  = 1'b0;
        gs.miss_right = 1'b0;

        //   r t b l r   st sl sr go rr dir win
        add(1,0,0,0,0,   0, 0, 0, 0, 0, 1, 0);   // reset state
        add(0,0,0,0,0,   0, 0, 0, 0, 0, 1, 0);
        add(0,1,0,1,1,   0, 0, 0, 0, 0, 1, 0);   // misses ignored in IDLE
        add(0,0,1,0,0,   1, 0, 0, 0, 1, 1, 0);   // serve: round_reset pulse
        add(0,0,0,0,0,   1, 0, 0, 0, 0, 1, 0);
        add(0,1,0,0,0,   1, 0, 0, 0, 0, 1, 0);
        add(0,0,0,1,0,   1, 0, 0, 0, 0, 1, 0);   // miss ignored in SERVE
        add(0,1,0,0,0,   2, 0, 0, 1, 0, 1, 0);   // second tick -> PLAY
        add(0,0,1,0,0,   2, 0, 0, 1, 0, 1, 0);   // serve_btn ignored in PLAY
        add(0,0,0,0,1,   3, 1, 0, 0, 0, 1, 0);   // miss_right: left scores
        add(0,0,0,1,0,   3, 1, 0, 0, 0, 1, 0);   // miss ignored in POINT
        add(0,1,0,0,0,   3, 1, 0, 0, 0, 1, 0);
        add(0,1,0,0,0,   1, 1, 0, 0, 1, 1, 0);   // back to SERVE with pulse
        add(0,1,0,0,0,   1, 1, 0, 0, 0, 1, 0);   // tick in entry cycle counts
        add(0,1,0,0,0,   2, 1, 0, 1, 0, 1, 0);
        add(0,0,0,1,1,   3, 1, 0, 0, 0, 1, 0);   // double miss: no score
        add(0,1,0,0,0,   3, 1, 0, 0, 0, 1, 0);
        add(0,1,0,0,0,   1, 1, 0, 0, 1, 1, 0);
        add(0,1,0,0,0,   1, 1, 0, 0, 0, 1, 0);
        add(0,1,0,0,0,   2, 1, 0, 1, 0, 1, 0);
        add(0,0,0,1,0,   3, 1, 1, 0, 0, 0, 0);   // miss_left: right scores, dir 0
        add(0,1,0,0,0,   3, 1, 1, 0, 0, 0, 0);
        add(0,1,0,0,0,   1, 1, 1, 0, 1, 0, 0);
        add(0,1,0,0,0,   1, 1, 1, 0, 0, 0, 0);
        add(0,1,0,0,0,   2, 1, 1, 1, 0, 0, 0);
        add(0,0,0,1,0,   3, 1, 2, 0, 0, 0, 0);   // right reaches WIN_SCORE
        add(0,1,1,0,0,   3, 1, 2, 0, 0, 0, 0);   // serve_btn ignored in POINT
        add(0,1,0,0,0,   4, 1, 2, 0, 0, 0, 1);   // OVER, right wins
        add(0,1,0,1,1,   4, 1, 2, 0, 0, 0, 1);   // scores hold in OVER
        add(0,0,1,0,0,   1, 0, 0, 0, 1, 1, 0);   // restart clears scores

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].t, tbl[i].b, tbl[i].ml, tbl[i].mr);
            $display("vec %0d: in r=%0d t=%0d b=%0d ml=%0d mr=%0d -> state=%0d sl=%0d sr=%0d start=%0d rr=%0d",
                     i, tbl[i].r, tbl[i].t, tbl[i].b, tbl[i].ml, tbl[i].mr,
                     gs.state, gs.score_l, gs.score_r, gs.start, gs.round_reset);
            check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].sl, tbl[i].sr,
                       tbl[i].go, tbl[i].rr, tbl[i].dir, tbl[i].win);
        end

        // Reset in the middle of a SERVE countdown with a nonzero score
        apply(1,0,0,0,0);
        apply(0,0,1,0,0);
        apply(0,1,0,0,0);
        apply(0,1,0,0,0);
        apply(0,0,0,0,1);
        apply(0,1,0,0,0);
        apply(0,1,0,0,0);
        apply(0,1,0,0,0);
        check_outs("mid_serve_pre", 1, 1, 0, 0, 0, 1, 0);
        apply(1,1,0,0,0);
        $display("seq reset_mid_serve: state=%0d sl=%0d sr=%0d rr=%0d", gs.state, gs.score_l, gs.score_r, gs.round_reset);
        check_outs("mid_serve_reset", 0, 0, 0, 0, 0, 1, 0);

        // No frame_tick for 100 cycles: SERVE must hold
        apply(0,0,1,0,0);
        for (int i = 0; i < 100; i++) begin
            apply(0,0,0,0,0);
            chk("hold.state", 32'(gs.state), 1);
            chk("hold.start", 32'(gs.start), 0);
        end
        $display("seq serve_hold: state=%0d start=%0d after 100 idle cycles", gs.state, gs.start);
        apply(0,1,0,0,0);
        apply(0,1,0,0,0);
        check_outs("hold_release", 2, 0, 0, 1, 0, 1, 0);

        // Random traffic against the model
        apply(1,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            logic r, t, b, ml, mr;
            r  = ($urandom_range(0, 199) == 0);
            t  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 7) == 0);
            ml = ($urandom_range(0, 9) == 0);
            mr = ($urandom_range(0, 9) == 0);
            apply(r, t, b, ml, mr);
            check_outs($sformatf("rnd%0d", i), m_phase, m_sl, m_sr, m_start, m_rr, m_dir, m_win);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL provide parameter WIN_SCORE, default 7, meaning the score that ends a match (1..15).
REQ-002 SHALL provide parameter SERVE_FRAMES, default 60, meaning the frame_tick count spent in SERVE before play (>=1).
REQ-003 SHALL provide parameter POINT_FRAMES, default 90, meaning the frame_tick count spent in POINT after a miss (>=1).
REQ-004 SHALL have port clk  input  1  master clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset; clock clk.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 SHALL have port serve_btn  input  1  level; requests match start or restart.
REQ-008 SHALL have port miss_left  input  1  ball passed the left paddle; right player scores.
REQ-009 SHALL have port miss_right  input  1  ball passed the right paddle; left player scores.
REQ-010 SHALL have port round_reset  output  1  one-cycle pulse returning the paddles and ball to start positions.
REQ-011 SHALL have port start  output  1  high only in PLAY; enables paddle and ball motion.
REQ-012 SHALL have port score_l  output  4  left player score.
REQ-013 SHALL have port score_r  output  4  right player score.
REQ-014 SHALL have port serve_dir  output  1  0 = serve toward left, 1 = serve toward right.
REQ-015 SHALL have port winner  output  1  0 = left, 1 = right; valid only in OVER.
REQ-016 SHALL have port state  output  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Function
REQ-017 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-018 SHALL implement states IDLE, SERVE, PLAY, POINT, OVER; unused encodings SHALL go to IDLE on the next clk.
REQ-019 IDLE: start=0; on serve_btn=1, SHALL clear both scores, set serve_dir=1, and enter SERVE.
REQ-020 On every entry to SERVE, SHALL pulse round_reset high for exactly the first SERVE cycle and load the frame counter with SERVE_FRAMES-1.
REQ-021 In SERVE and POINT, on frame_tick with counter==0, SHALL leave the state; on frame_tick otherwise, SHALL decrement the counter. The state is therefore exited on the Nth tick, N=SERVE_FRAMES or POINT_FRAMES.
REQ-022 SERVE SHALL exit to PLAY; frame_ticks in the entry cycle SHALL count.
REQ-023 PLAY: start=1; on miss_left alone, SHALL increment score_r, set serve_dir=0 (serve toward the loser), and enter POINT.
REQ-024 PLAY: on miss_right alone, SHALL increment score_l, set serve_dir=1, and enter POINT.
REQ-025 PLAY: on miss_left and miss_right in the same cycle, SHALL change no score, keep serve_dir, and enter POINT.
REQ-026 SHALL ignore miss_left and miss_right in every state other than PLAY.
REQ-027 On entry to POINT, SHALL drop start in the same cycle the state changes and load the counter with POINT_FRAMES-1.
REQ-028 On POINT exit, SHALL enter OVER if score_l==WIN_SCORE or score_r==WIN_SCORE, otherwise SERVE.
REQ-029 On entry to OVER, SHALL set winner=1 if score_r==WIN_SCORE, else winner=0; start=0.
REQ-030 OVER: scores SHALL hold; on serve_btn=1, SHALL clear both scores, set serve_dir=1, and enter SERVE.
REQ-031 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-032 SHALL ignore serve_btn outside IDLE and OVER.

Reset
REQ-033 When reset=1 at posedge clk, SHALL set: state=IDLE, counter=0, score_l=0, score_r=0, start=0, round_reset=0, serve_dir=1, winner=0.
REQ-034 Reset SHALL take priority over all inputs in any state, including mid-SERVE and mid-POINT countdowns.

Verification
(Use WIN_SCORE=2, SERVE_FRAMES=2, POINT_FRAMES=2.)
REQ-035 Reset then serve_btn pulse -> state=1, round_reset high for exactly one cycle, start=0; second frame_tick -> state=2, start=1.
REQ-036 In PLAY, miss_right pulse -> next cycle state=3, score_l=1, start=0, serve_dir=1; two frame_ticks later -> state=1 with a round_reset pulse.
REQ-037 In PLAY, miss_left and miss_right together -> state=3, scores unchanged; a miss asserted in SERVE or POINT -> no score change.
REQ-038 Two miss_left points -> after the POINT countdown, state=4, score_r=2, winner=1; serve_btn -> state=1, scores 0.
REQ-039 reset asserted mid-SERVE countdown with score_l=1 -> next cycle state=0, all scores 0, start=0, no round_reset pulse.
REQ-040 frame_tick held low in SERVE for 100 cycles -> state stays 1, start stays 0.
